// File: rtl/gb_irq_ctrl_pkg.sv
// gb_irq_ctrl_pkg: shared definitions for the Gameboy interrupt controller.
//   Source bit indices, register addresses, vector layout defaults, FSM
//   state type and the vector computation helper.
package gb_irq_ctrl_pkg;

   localparam int unsigned DEF_NUM_IRQ    = 5;
   localparam logic [7:0]  DEF_VEC_BASE   = 8'h40;
   localparam int unsigned DEF_VEC_STRIDE = 8;

   localparam int unsigned IRQ_VBLANK = 0;
   localparam int unsigned IRQ_STAT   = 1;
   localparam int unsigned IRQ_TIMER  = 2;
   localparam int unsigned IRQ_SERIAL = 3;
   localparam int unsigned IRQ_JOYPAD = 4;

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   typedef enum logic {
      StIdle = 1'b0,
      StAck  = 1'b1
   } irq_state_e;

   // RST vector of source idx; 8-bit wrap is intended.
   function automatic logic [7:0] irq_vector(logic [7:0] base, int unsigned stride,
                                             int unsigned idx);
      return 8'(32'(base) + idx * stride);
   endfunction

endpackage

// File: rtl/gb_irq_ctrl_if.sv
// gb_irq_ctrl_if: CPU-side bus of the interrupt controller.
//   cpu_sel_if/cpu_sel_ie : register selects (IF at FF0F, IE at FFFF)
//   cpu_wr, cpu_di        : write strobe and data
//   cpu_do                : combinational read data
//   cpu_ack               : interrupt acknowledge level from the CPU
//   irq_n, irq_vec        : registered interrupt line and RST vector
interface gb_irq_ctrl_if;

   logic       cpu_sel_if;
   logic       cpu_sel_ie;
   logic       cpu_wr;
   logic [7:0] cpu_di;
   logic [7:0] cpu_do;
   logic       cpu_ack;
   logic       irq_n;
   logic [7:0] irq_vec;

   modport master (
      output cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, cpu_ack,
      input  cpu_do, irq_n, irq_vec
   );

   modport slave (
      input  cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, cpu_ack,
      output cpu_do, irq_n, irq_vec
   );

endinterface

// File: rtl/gb_irq_prio.sv
// gb_irq_prio: combinational lowest-set-bit encoder.
//   pend_i  : pending sources, bit 0 highest priority
//   valid_o : any bit set
//   index_o : index of the lowest set bit (0 when none)
module gb_irq_prio #(
   parameter int unsigned N = 5,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    pend_i,
   output logic            valid_o,
   output logic [IdxW-1:0] index_o
);

   always_comb begin
      valid_o = |pend_i;
      index_o = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (pend_i[i]) index_o = IdxW'(i);
      end
   end

endmodule

// File: rtl/gb_irq_ctrl.sv
// gb_irq_ctrl: Gameboy interrupt controller owning IF (FF0F) and IE (FFFF).
//   clk, reset_n : CPU clock, asynchronous active-low reset
//   irq_req      : source request levels, [0]VBlank .. [4]Joypad
//   bus          : CPU register access, acknowledge, irq_n and irq_vec
module gb_irq_ctrl
   import gb_irq_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IRQ    = DEF_NUM_IRQ,
   parameter logic [7:0]  VEC_BASE   = DEF_VEC_BASE,
   parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_req,
   gb_irq_ctrl_if.slave       bus
);

   localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [NUM_IRQ-1:0] if_q, if_d;
   logic [NUM_IRQ-1:0] req_q;
   logic [NUM_IRQ-1:0] req_edge;
   logic [NUM_IRQ-1:0] pend;
   logic [7:0]         ie_q, ie_d;
   logic [7:0]         vec_q;
   logic               ack_q;
   logic               irq_n_q;
   logic               ack_rise;
   logic               prio_valid;
   logic [IdxW-1:0]    prio_idx;
   irq_state_e         state_q;

   assign req_edge = irq_req & ~req_q;
   assign pend     = if_q & ie_q[NUM_IRQ-1:0];
   assign ack_rise = (state_q == StIdle) && bus.cpu_ack && !ack_q;

   gb_irq_prio #(
      .N(NUM_IRQ)
   ) u_prio (
      .pend_i  (pend),
      .valid_o (prio_valid),
      .index_o (prio_idx)
   );

   // Later assignments win: CPU write < ack clear < request edge.
   always_comb begin
      if_d = if_q;
      ie_d = ie_q;
      if (bus.cpu_wr && bus.cpu_sel_if) if_d = bus.cpu_di[NUM_IRQ-1:0];
      if (bus.cpu_wr && bus.cpu_sel_ie) ie_d = bus.cpu_di;
      if (ack_rise && prio_valid) if_d = if_d & ~(NUM_IRQ'(1) << prio_idx);
      if_d = if_d | req_edge;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_q  <= '0;
         ie_q  <= '0;
         req_q <= '0;
         ack_q <= 1'b0;
      end else begin
         if_q  <= if_d;
         ie_q  <= ie_d;
         req_q <= irq_req;
         ack_q <= bus.cpu_ack;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         irq_n_q <= 1'b1;
         vec_q   <= 8'h00;
      end else begin
         case (state_q)
            StIdle: begin
               if (ack_rise) begin
                  state_q <= StAck;
                  irq_n_q <= 1'b1;
                  // Empty pend means IE/IF changed under the CPU: hand it a null vector.
                  vec_q   <= prio_valid ? irq_vector(VEC_BASE, VEC_STRIDE, 32'(prio_idx))
                                        : 8'h00;
               end else begin
                  irq_n_q <= ~(|pend);
               end
            end
            StAck: begin
               irq_n_q <= 1'b1;
               if (!bus.cpu_ack) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.cpu_do = 8'hFF;
      if (bus.cpu_sel_if) begin
         bus.cpu_do[NUM_IRQ-1:0] = if_q;
      end else if (bus.cpu_sel_ie) begin
         bus.cpu_do = ie_q;
      end
   end

   assign bus.irq_n   = irq_n_q;
   assign bus.irq_vec = vec_q;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// tb_gb_irq_ctrl: scoreboard bench for gb_irq_ctrl. The driver applies one
// cycle of stimulus per negedge and pushes the reference model's expectations;
// a monitor pops them and compares read data and the registered outputs.
module tb_gb_irq_ctrl;

   typedef struct {
      logic [7:0] cdo;
      logic       irqn;
      logic [7:0] vec;
   } exp_t;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic [4:0] irq_req = 5'b0;

   int checks   = 0;
   int failures = 0;

   exp_t sb_q[$];

   // Reference model state: register contents and protocol status.
   int unsigned m_if, m_ie, m_req;
   bit          m_ack_prev, m_in_ack, m_irqn;
   logic [7:0]  m_vec;

   gb_irq_ctrl_if bus ();

   gb_irq_ctrl u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_req (irq_req),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned lowest(input int unsigned v);
      for (int i = 0; i < 5; i++) begin
         if (((v >> i) & 1) != 0) return 32'(i);
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_if = 0; m_ie = 0; m_req = 0;
      m_ack_prev = 0; m_in_ack = 0; m_irqn = 1; m_vec = 8'h00;
   endtask

   // One clock of stimulus; the model predicts this cycle's read data and the
   // outputs after the coming rising edge.
   task automatic step(input logic [4:0] req, input logic sif, input logic sie, input logic wr,
                       input logic [7:0] di, input logic ack);
      exp_t        e;
      int unsigned pend, nif, nie, k;
      @(negedge clk);
      irq_req = req;
      bus.cpu_sel_if = sif; bus.cpu_sel_ie = sie; bus.cpu_wr = wr;
      bus.cpu_di = di; bus.cpu_ack = ack;
      e.cdo = sif ? 8'(m_if | 32'hE0) : (sie ? 8'(m_ie) : 8'hFF);
      pend = m_if & m_ie & 32'h1F;
      nif  = m_if;
      nie  = m_ie;
      if (wr && sif) nif = 32'(di) & 32'h1F;
      if (wr && sie) nie = 32'(di);
      if (!m_in_ack && ack && !m_ack_prev) begin
         m_in_ack = 1; m_irqn = 1;
         if (pend != 0) begin
            k     = lowest(pend);
            nif   = nif & ~(32'd1 << k);
            m_vec = 8'(32'h40 + 8 * k);
         end else begin
            m_vec = 8'h00;
         end
      end else if (m_in_ack) begin
         m_irqn = 1;
         if (!ack) m_in_ack = 0;
      end else begin
         m_irqn = (pend == 0);
      end
      nif  = nif | (32'(req) & ~m_req);
      m_if = nif & 32'h1F;
      m_ie = nie & 32'hFF;
      m_req = 32'(req);
      m_ack_prev = ack;
      e.irqn = m_irqn;
      e.vec  = m_vec;
      sb_q.push_back(e);
   endtask

   task automatic rd_if(input logic [4:0] req, input logic ack);
      step(req, 1'b1, 1'b0, 1'b0, 8'h00, ack);
   endtask

   task automatic wr_if(input logic [7:0] d);
      step(5'b0, 1'b1, 1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic wr_ie(input logic [7:0] d);
      step(5'b0, 1'b0, 1'b1, 1'b1, d, 1'b0);
   endtask

   // Monitor: read data mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_cpu_do", bus.cpu_do, e.cdo);
            @(posedge clk);
            #1;
            chk("sb_irq_n", {7'b0, bus.irq_n}, {7'b0, e.irqn});
            chk("sb_irq_vec", bus.irq_vec, e.vec);
         end
      end
   end

   initial begin
      logic ack_r;
      logic [4:0] req_r;
      int sel;
      bus.cpu_sel_if = 1'b0; bus.cpu_sel_ie = 1'b0; bus.cpu_wr = 1'b0;
      bus.cpu_di = 8'h00; bus.cpu_ack = 1'b0;
      model_reset();

      #1 reset_n = 1'b0;
      #2;
      chk("rst_irq_n", {7'b0, bus.irq_n}, 8'h01);
      chk("rst_irq_vec", bus.irq_vec, 8'h00);
      #19 reset_n = 1'b1;

      // Single-cycle timer pulse: IF set at the edge, irq_n low one edge later.
      wr_ie(8'h04);
      rd_if(5'b00100, 1'b0);
      @(posedge clk); #1;
      chk("t1_irq_n_e0", {7'b0, bus.irq_n}, 8'h01);
      rd_if(5'b00000, 1'b0);
      #2 chk("t1_if_read", bus.cpu_do, 8'hE4);
      @(posedge clk); #1;
      chk("t1_irq_n_e1", {7'b0, bus.irq_n}, 8'h00);

      // Two pending sources served lowest index first.
      wr_if(8'h12);
      wr_ie(8'h1F);
      rd_if(5'b0, 1'b1);
      @(posedge clk); #1;
      chk("t2_vec_stat", bus.irq_vec, 8'h48);
      chk("t2_irq_n_ack", {7'b0, bus.irq_n}, 8'h01);
      rd_if(5'b0, 1'b1);
      #2 chk("t2_if_after_ack", bus.cpu_do, 8'hF0);
      rd_if(5'b0, 1'b0);
      rd_if(5'b0, 1'b0);
      @(posedge clk); #1;
      chk("t2_irq_n_again", {7'b0, bus.irq_n}, 8'h00);
      rd_if(5'b0, 1'b1);
      @(posedge clk); #1;
      chk("t2_vec_joypad", bus.irq_vec, 8'h60);
      rd_if(5'b0, 1'b0);
      rd_if(5'b0, 1'b0);

      // Request edge beats CPU write, and beats its own ack clear.
      step(5'b00001, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      rd_if(5'b0, 1'b0);
      #2 chk("t3_edge_vs_write", bus.cpu_do, 8'hE1);
      rd_if(5'b00001, 1'b1);
      @(posedge clk); #1;
      chk("t3_vec_vblank", bus.irq_vec, 8'h40);
      rd_if(5'b0, 1'b1);
      #2 chk("t3_edge_vs_ack", bus.cpu_do, 8'hE1);
      rd_if(5'b0, 1'b0);
      rd_if(5'b0, 1'b0);

      // Masked request: no interrupt, null vector on ack, IF untouched.
      wr_ie(8'h00);
      wr_if(8'h01);
      for (int i = 0; i < 3; i++) begin
         rd_if(5'b0, 1'b0);
         @(posedge clk); #1;
         chk("t4_irq_n_masked", {7'b0, bus.irq_n}, 8'h01);
      end
      rd_if(5'b0, 1'b1);
      @(posedge clk); #1;
      chk("t4_vec_null", bus.irq_vec, 8'h00);
      rd_if(5'b0, 1'b1);
      #2 chk("t4_if_kept", bus.cpu_do, 8'hE1);
      rd_if(5'b0, 1'b0);
      rd_if(5'b0, 1'b0);

      // A held level sets IF once only.
      for (int i = 0; i < 100; i++) begin
         if (i == 10) step(5'b01000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
         else rd_if(5'b01000, 1'b0);
      end
      #2 chk("t5_level_no_reset", bus.cpu_do, 8'hE0);
      rd_if(5'b00000, 1'b0);
      rd_if(5'b01000, 1'b0);
      rd_if(5'b00000, 1'b0);
      #2 chk("t5_new_edge", bus.cpu_do, 8'hE8);
      wr_if(8'h00);

      // Asynchronous reset while in ACK.
      wr_ie(8'h04);
      wr_if(8'h04);
      rd_if(5'b0, 1'b1);
      @(posedge clk); #1;
      chk("t6_vec_timer", bus.irq_vec, 8'h50);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_irq_n", {7'b0, bus.irq_n}, 8'h01);
      chk("t6_irq_vec", bus.irq_vec, 8'h00);
      chk("t6_if", bus.cpu_do, 8'hE0);
      bus.cpu_sel_if = 1'b0; bus.cpu_sel_ie = 1'b1;
      #1;
      chk("t6_ie", bus.cpu_do, 8'h00);
      reset_n = 1'b1;
      model_reset();

      // Randomized traffic against the model.
      ack_r = 1'b0;
      req_r = 5'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) ack_r = ~ack_r;
         req_r = req_r ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
         sel = $urandom_range(0, 2);
         step(req_r, sel == 1, sel == 2, $urandom_range(0, 3) == 0, 8'($urandom), ack_r);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
